// File: rtl/wb_irq_ctrl_pkg.sv
// Shared register map constants and helpers for the Wishbone interrupt controller.
// The optional priority ID register is enabled with WB_IRQ_CTRL_PRIO_EN.
package wb_irq_ctrl_pkg;

    localparam logic [2:0] ADR_RAW     = 3'd0;
    localparam logic [2:0] ADR_PENDING = 3'd1;
    localparam logic [2:0] ADR_MASK    = 3'd2;
    localparam logic [2:0] ADR_EDGE    = 3'd3;
    localparam logic [2:0] ADR_SET     = 3'd4;
    localparam logic [2:0] ADR_ACTIVE  = 3'd5;
    localparam logic [2:0] ADR_ID      = 3'd6;

    localparam int unsigned ID_VALID_BIT = 31;
    localparam int unsigned ID_IDX_W     = 5;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ID_IDX_W-1:0] lowest_idx(input logic [31:0] v);
        logic [ID_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = ID_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser chain with edge history; rise flags a 0->1 of the synced level.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone B3 interrupt controller: sync, level/edge capture, pending, mask, CPU irq vector.
// Defining WB_IRQ_CTRL_PRIO_EN adds a registered lowest-active-index ID register at address 6.
module wb_irq_ctrl
    import wb_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [2:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [NUM_SRC-1:0] irq_o
);

    logic [NUM_SRC-1:0] s, rise, set_cond, w1c, sw_set, active;
    logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, edge_mode_q, wdat;
    logic               ack_q, err_q, req, mapped, wr_en;
    logic [31:0]        dat_q, rdat;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (wb_clk_i),
            .rst_n(wb_rst_ni),
            .src  (irq_src_i[i]),
            .s    (s[i]),
            .rise (rise[i])
        );
    end

    assign active = pend_q & mask_q;

`ifdef WB_IRQ_CTRL_PRIO_EN
    logic [31:0] id_q, id_d;

    always_comb begin
        id_d                   = '0;
        id_d[ID_VALID_BIT]     = |active;
        id_d[ID_IDX_W-1:0]     = lowest_idx(32'(active));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) id_q <= '0;
        else            id_q <= id_d;
    end
`endif

    // A new request is only accepted while no response is being presented.
    assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wdat = wb_dat_i[NUM_SRC-1:0];

    always_comb begin
        mapped = 1'b1;
        rdat   = '0;
        case (wb_adr_i)
            ADR_RAW:     rdat = 32'(s);
            ADR_PENDING: rdat = 32'(pend_q);
            ADR_MASK:    rdat = 32'(mask_q);
            ADR_EDGE:    rdat = 32'(edge_mode_q);
            ADR_SET:     rdat = '0;
            ADR_ACTIVE:  rdat = 32'(active);
`ifdef WB_IRQ_CTRL_PRIO_EN
            ADR_ID:      rdat = id_q;
`endif
            default:     mapped = 1'b0;
        endcase
    end

    assign wr_en    = req & wb_we_i & mapped & (wb_sel_i == 4'hF);
    assign w1c      = (wr_en && wb_adr_i == ADR_PENDING) ? wdat : '0;
    assign sw_set   = (wr_en && wb_adr_i == ADR_SET) ? wdat : '0;
    assign set_cond = (edge_mode_q & rise) | (~edge_mode_q & s);
    assign pend_d   = (pend_q & ~w1c) | set_cond | sw_set;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pend_q      <= '0;
            mask_q      <= '0;
            edge_mode_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_en && wb_adr_i == ADR_MASK) mask_q <= wdat;
            if (wr_en && wb_adr_i == ADR_EDGE) edge_mode_q <= wdat;
            ack_q <= req & mapped;
            err_q <= req & ~mapped;
            dat_q <= (req && mapped && !wb_we_i) ? rdat : '0;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = active;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Scoreboard bench for wb_irq_ctrl: bus tasks queue expected responses, a monitor checks them.
module tb_wb_irq_ctrl;
    import wb_irq_ctrl_pkg::*;

    localparam int unsigned NUM_SRC = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [2:0]         adr = '0;
    logic [31:0]        dat_i = '0;
    logic [3:0]         sel = '0;
    logic               we = 1'b0;
    logic               cyc = 1'b0;
    logic               stb = 1'b0;
    logic [31:0]        dat_o;
    logic               ack;
    logic               err;
    logic [NUM_SRC-1:0] src = '0;
    logic [NUM_SRC-1:0] irq;

    typedef struct {
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic        chk_irq;
        logic [31:0] exp_irq;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;

    wb_irq_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(2)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .irq_src_i(src),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented response.
    initial begin
        exp_t e;
        logic resp;
        logic last_resp;
        last_resp = 1'b0;
        forever begin
            @(negedge clk);
            resp = ack | err;
            if (resp) begin
                chk("resp_one_cycle", 32'(last_resp), 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b required none", ack, err);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_err"}, 32'(err), 32'(e.exp_err));
                    chk({e.name, "_ack"}, 32'(ack), 32'(!e.exp_err));
                    chk({e.name, "_lat"}, 32'(cyc_cnt - e.issue), 32'd1);
                    if (e.chk_dat) chk({e.name, "_dat"}, dat_o, e.exp_dat);
                    if (e.chk_irq) chk({e.name, "_irq"}, 32'(irq), e.exp_irq);
                end
            end
            last_resp = resp;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle and no response pending.
    task automatic access(input logic [2:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] sl, input logic ee, input logic cd,
                          input logic [31:0] ed, input logic ci, input logic [31:0] ei,
                          input string nm);
        exp_t e;
        bit   got;
        e.exp_err = ee;
        e.chk_dat = cd;
        e.exp_dat = ed;
        e.chk_irq = ci;
        e.exp_irq = ei;
        e.issue   = cyc_cnt;
        e.name    = nm;
        sb.push_back(e);
        adr = a; we = w; dat_i = d; sel = sl; cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack || err) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no response required ack or err", nm);
            void'(sb.pop_back());
        end
        tick(1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string nm);
        access(a, 1'b1, d, 4'hF, 1'b0, 1'b0, '0, 1'b0, '0, nm);
    endtask

    task automatic wri(input logic [2:0] a, input logic [31:0] d, input logic [31:0] ei,
                       input string nm);
        access(a, 1'b1, d, 4'hF, 1'b0, 1'b0, '0, 1'b1, ei, nm);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] ed, input string nm);
        access(a, 1'b0, '0, 4'hF, 1'b0, 1'b1, ed, 1'b0, '0, nm);
    endtask

    initial begin
        tick(3);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        tick(2);

        rd(ADR_RAW, 32'h0, "rst_raw");
        rd(ADR_PENDING, 32'h0, "rst_pend");
        rd(ADR_MASK, 32'h0, "rst_mask");
        rd(ADR_EDGE, 32'h0, "rst_edge");
        rd(ADR_SET, 32'h0, "rst_set");
        rd(ADR_ACTIVE, 32'h0, "rst_active");

        // Level mode on bit 2.
        wri(ADR_MASK, 32'h0008_0004, 32'h0, "mask_wr");
        wr(ADR_EDGE, 32'h0, "edge_wr0");
        rd(ADR_MASK, 32'h0008_0004, "mask_rd");
        src[2] = 1'b1;
        tick(2);
        chk("lvl_irq_early", 32'(irq), 32'h0);
        tick(1);
        chk("lvl_irq_on", 32'(irq), 32'h4);
        rd(ADR_RAW, 32'h4, "raw_rd");
        wri(ADR_PENDING, 32'h4, 32'h4, "lvl_w1c_hi");
        rd(ADR_PENDING, 32'h4, "lvl_pend_hi");
        src[2] = 1'b0;
        tick(3);
        wri(ADR_PENDING, 32'h4, 32'h0, "lvl_w1c_lo");
        rd(ADR_PENDING, 32'h0, "lvl_pend_lo");

        // Edge mode on bit 19.
        wr(ADR_EDGE, 32'h0008_0000, "edge_wr19");
        src[19] = 1'b1;
        tick(1);
        src[19] = 1'b0;
        tick(4);
        rd(ADR_PENDING, 32'h0008_0000, "edge_pulse");
        chk("edge_irq", 32'(irq), 32'h0008_0000);
        wri(ADR_PENDING, 32'h0008_0000, 32'h0, "edge_w1c");
        rd(ADR_PENDING, 32'h0, "edge_clr");
        src[19] = 1'b1;
        tick(4);
        rd(ADR_PENDING, 32'h0008_0000, "edge_hold");
        wri(ADR_PENDING, 32'h0008_0000, 32'h0, "edge_w1c2");
        tick(4);
        rd(ADR_PENDING, 32'h0, "edge_noretrig");
        src[19] = 1'b0;
        tick(3);

        // Software set and unmask.
        wr(ADR_MASK, 32'h0, "mask_zero");
        wri(ADR_SET, 32'h1, 32'h0, "sw_set");
        rd(ADR_PENDING, 32'h1, "sw_pend");
        rd(ADR_SET, 32'h0, "set_rd");
        wri(ADR_MASK, 32'h1, 32'h1, "unmask");
        rd(ADR_ACTIVE, 32'h1, "active_rd");
        access(ADR_MASK, 1'b1, 32'h0, 4'h3, 1'b0, 1'b0, '0, 1'b1, 32'h1, "part_wr");
        rd(ADR_MASK, 32'h1, "part_mask");
        wr(ADR_PENDING, 32'h1, "sw_w1c");
        rd(ADR_PENDING, 32'h0, "sw_clr");

        // Rising edge and W1C on the same edge: set wins.
        wr(ADR_MASK, 32'h0008_0000, "mask19");
        src[19] = 1'b1;
        tick(2);
        wri(ADR_PENDING, 32'h0008_0000, 32'h0008_0000, "setwins");
        rd(ADR_PENDING, 32'h0008_0000, "setwins_rd");
        src[19] = 1'b0;
        tick(3);
        wri(ADR_PENDING, 32'h0008_0000, 32'h0, "setwins_clr");

        // Unmapped addresses.
        access(3'd7, 1'b0, '0, 4'hF, 1'b1, 1'b0, '0, 1'b0, '0, "rd7");
        access(3'd7, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, '0, 1'b0, '0, "wr7");
        rd(ADR_MASK, 32'h0008_0000, "mask_keep");
        rd(ADR_PENDING, 32'h0, "pend_keep");
`ifdef WB_IRQ_CTRL_PRIO_EN
        wr(ADR_MASK, 32'h0008_0004, "mask_prio");
        wr(ADR_SET, 32'h0008_0004, "set_prio");
        rd(ADR_ACTIVE, 32'h0008_0004, "active_prio");
        rd(ADR_ID, 32'h8000_0002, "id_rd");
        wr(ADR_PENDING, 32'h0008_0004, "clr_prio");
        tick(1);
        rd(ADR_ID, 32'h0, "id_none");
`else
        access(ADR_ID, 1'b0, '0, 4'hF, 1'b1, 1'b0, '0, 1'b0, '0, "rd6");
        access(ADR_ID, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, '0, 1'b0, '0, "wr6");
        rd(ADR_PENDING, 32'h0, "pend_keep6");
`endif

        tick(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Wishbone B3 slave interrupt controller that feeds the CPU `irq_i` vector directly.
- Collects raw interrupt sources such as the UART, the interrupt generator and future peripherals.
- For each source: synchronises it, captures it as level or rising-edge, holds it in a pending register, masks it, and drives the CPU interrupt vector.
- Software can clear pending bits (write-1-to-clear) and raise software-triggered pending bits.

Parameters:
- NUM_SRC, 32: number of interrupt sources/outputs, legal range 1..32.
- SYNC_STAGES, 2: synchroniser flops per source, legal range 2..3.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  3  word address (register index).
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; only 4'hF writes are honoured, partial writes are ignored but still acked.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error on an unmapped address.
- irq_src_i  in  NUM_SRC  raw asynchronous interrupt sources.
- irq_o  out  NUM_SRC  masked pending vector to the CPU.

Behaviour:
- Reset (wb_rst_ni=0, asynchronous): all synchronisers, edge history, PENDING, MASK and EDGE are cleared; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
- Register map (word index):
  - 0 RAW: read-only, synchronised source levels.
  - 1 PENDING: read; a write of 1 clears the bit (W1C).
  - 2 MASK: read/write, 1 = enabled.
  - 3 EDGE: read/write, 1 = rising-edge mode, 0 = level mode.
  - 4 SET: write-only, 1 sets the pending bit; reads return 0.
  - 5 ACTIVE: read-only, PENDING & MASK.
  - 6..7: unmapped.
- Bits at or above NUM_SRC read as 0; writes to them are ignored.
- Bus handshake:
  - ack/err is registered and asserts one cycle after wb_cyc_i & wb_stb_i are seen with ack/err low.
  - It is held for exactly one cycle, then drops, so each access is at least 2 cycles.
  - wb_dat_o is valid in the ack cycle.
  - A write takes effect on the same edge that raises ack.
  - An unmapped address raises wb_err_o instead of ack; no register changes.
  - Dropping stb/cyc before ack aborts the access with no side effects.
- Per-source pipeline:
  - raw input → SYNC_STAGES flops → synced value s.
  - Edge history register p <= s every cycle, independent of mode.
  - Set condition: edge mode: s & ~p; level mode: s.
- Pending update each cycle: pend <= (pend & ~w1c) | set_cond | sw_set.
  - If set and clear happen in the same cycle, set wins.
  - Level mode with the source still high: a W1C is overridden and the bit re-asserts the same cycle.
- irq_o = PENDING & MASK, driven combinationally from flops with no extra delay.
- Latency: a source rising just before edge 0 gives s high after SYNC_STAGES edges; pending and irq_o are high after SYNC_STAGES+1 edges.
- A SET write shows on irq_o in the ack cycle, if masked in.
- Masking does not clear pending; unmasking a pending bit asserts irq_o on the edge that writes MASK.
- Changing EDGE creates no spurious edge, because p always tracks s.
- A source pulse shorter than one clock may be lost; sources must be held at least one clock.
- Reset asserted mid-access: ack is killed immediately; no partial write survives.

Optional Feature:
- Macro: WB_IRQ_CTRL_PRIO_EN.
- When defined:
  - Address 6 becomes the read-only ID register: bit31 = any ACTIVE bit set, bits[4:0] = lowest-numbered ACTIVE index, all other bits 0.
  - ID is a registered encoder, one cycle behind ACTIVE.
  - With nothing active, ID reads 0.
- When not defined:
  - Address 6 returns wb_err_o like any unmapped address.
  - No encoder logic is built.

Decomposition:
- Package wb_irq_ctrl_pkg holds:
  - register index constants (ADR_RAW=0 through ADR_ACTIVE=5, ADR_ID=6);
  - ID_VALID_BIT=31;
  - a localparam for the ID index width (5).
- One sub-module, irq_sync_edge:
  - per-source SYNC_STAGES synchroniser plus edge history;
  - outputs s and rise;
  - instantiated NUM_SRC times in a generate loop.

Test Plan:
- Reset then read all registers → all reads 0, irq_o=0, every access acked exactly one cycle after stb.
- MASK=0x00080004, EDGE=0, hold irq_src_i[2]=1 → irq_o=0x4 after 3 edges; W1C PENDING=0x4 while the source is high → PENDING still reads 0x4; drop the source and W1C again → irq_o=0.
- EDGE=0x00080000, 1-cycle-wide pulse on bit 19 → PENDING=0x80000 latched after the pulse ends; W1C 0x80000 → 0; a held-high source produces no retrigger.
- Write SET=0x1 with MASK=0 → PENDING=0x1, irq_o=0; then MASK=0x1 → irq_o=0x1 in that write's ack cycle.
- Same cycle: edge on bit 19 and W1C of bit 19 → PENDING bit 19 remains 1 (set wins).
- Access address 7 (and address 6 without WB_IRQ_CTRL_PRIO_EN) → wb_err_o=1 for one cycle, ack=0, no state change.
- With WB_IRQ_CTRL_PRIO_EN: ACTIVE=0x00080004 → ID reads 0x80000002.
